dmx_route_sequencer: RTL and testbench

//  Upstream driver for the 1x16 demux (ports a, s0..s3, y[15:0]; s0 = select MSB).

---
 rtl/dmx_pkg.sv | 27 ++
 rtl/dmx_dwell_timer.sv | 32 +++
 rtl/dmx_route_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_dmx_route_sequencer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmx_pkg.sv
// Shared definitions for the 1x16 demux route sequencer.
//   NUM_CHAN / CHAN_W : demux fan-out and select width
//   LAST_CHAN         : final channel of a scan (the counter stops here)
//   dmx_state_e       : sequencer FSM encoding
//   chan_onehot()     : expected demux output pattern for a channel
package dmx_pkg;

  localparam int NUM_CHAN = 16;
  localparam int CHAN_W   = 4;

  localparam logic [CHAN_W-1:0] LAST_CHAN = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_DRIVE   = 2'd2,
    ST_RELEASE = 2'd3
  } dmx_state_e;

  function automatic logic [NUM_CHAN-1:0] chan_onehot(input logic [CHAN_W-1:0] ch);
    logic [NUM_CHAN-1:0] v;
    v = '0;
    v[ch] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/dmx_dwell_timer.sv
// Loadable down-counter used to time the SETUP and DRIVE phases.
//   clk, rst_n  : clock, asynchronous active-low reset
//   load_i      : load load_val_i (has priority over decrement)
//   load_val_i  : phase length minus one
//   en_i        : decrement by one, saturating at zero
//   done_o      : counter is zero (current cycle is the last of the phase)
module dmx_dwell_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         done_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign done_o = (count_q == '0);

endmodule

// File: rtl/dmx_route_sequencer.sv
// Break-before-make driver for a 1x16 demux (a, s0..s3; s0 = select MSB).
// Takes {data, channel} requests on a valid/ready handshake, sets the select
// while a=0, holds data on a for DWELL_CYCLES, then releases a before any
// further select change. Scan mode walks channels 0..15 with one data bit.
//
// Handshake: a request transfers on a rising clk edge where in_valid and
// in_ready are both 1. in_ready is registered and high only in IDLE; a
// requester seeing in_ready=0 keeps in_valid (and its payload) asserted.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   request handshake
//   in_data, in_chan    bit to route and target channel (in_chan unused in scan)
//   in_scan             broadcast in_data to channels 0..15 in turn
//   dmx_a, dmx_s0..s3   demux data and select ({s0,s1,s2,s3} = channel)
//   dmx_strobe          high exactly while in DRIVE
//   busy                high outside IDLE
// Optional (macro DMX_CHECK_EN):
//   dmx_y               demux outputs fed back for checking
//   chk_err             sticky mismatch flag, cleared only by reset
module dmx_route_sequencer
  import dmx_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int DWELL_CYCLES  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_data,
  input  logic [CHAN_W-1:0] in_chan,
  input  logic              in_scan,
  output logic              dmx_a,
  output logic              dmx_s0,
  output logic              dmx_s1,
  output logic              dmx_s2,
  output logic              dmx_s3,
  output logic              dmx_strobe,
  output logic              busy
`ifdef DMX_CHECK_EN
  ,
  input  logic [NUM_CHAN-1:0] dmx_y,
  output logic                chk_err
`endif
);

  localparam int MAX_CYC = (SETTLE_CYCLES > DWELL_CYCLES) ? SETTLE_CYCLES : DWELL_CYCLES;
  localparam int TMR_W   = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC + 1);

  localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] DWELL_LOAD  = TMR_W'(DWELL_CYCLES - 1);

  dmx_state_e        state_q;
  logic [CHAN_W-1:0] chan_q;
  logic              data_q;
  logic              scan_q;
  logic              a_q;
  logic              strobe_q;
  logic              ready_q;
  logic              busy_q;

  logic              accept;
  logic              scan_more;
  logic              tmr_load;
  logic [TMR_W-1:0]  tmr_val;
  logic              tmr_en;
  logic              tmr_done;

  assign accept    = (state_q == ST_IDLE) && in_valid && ready_q;
  // A scan continues until channel 15 has been released; no wrap to 0.
  assign scan_more = scan_q && (chan_q != LAST_CHAN);

  // Timer is reloaded on entry to each timed state and counts down inside it.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          tmr_load = 1'b1;
          tmr_val  = SETTLE_LOAD;
        end
      end
      ST_SETUP: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          tmr_val  = DWELL_LOAD;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_DRIVE: begin
        tmr_en = !tmr_done;
      end
      ST_RELEASE: begin
        if (scan_more) begin
          tmr_load = 1'b1;
          tmr_val  = SETTLE_LOAD;
        end
      end
      default: ;
    endcase
  end

  dmx_dwell_timer #(.W(TMR_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .en_i       (tmr_en),
    .done_o     (tmr_done)
  );

  // chan_q is the select register itself: it only changes on entry to SETUP,
  // which is always from IDLE or RELEASE where a is already 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      chan_q   <= '0;
      data_q   <= 1'b0;
      scan_q   <= 1'b0;
      a_q      <= 1'b0;
      strobe_q <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            data_q  <= in_data;
            scan_q  <= in_scan;
            chan_q  <= in_scan ? '0 : in_chan;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ST_SETUP;
          end else begin
            ready_q <= 1'b1;
          end
        end
        ST_SETUP: begin
          if (tmr_done) begin
            a_q      <= data_q;
            strobe_q <= 1'b1;
            state_q  <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (tmr_done) begin
            a_q      <= 1'b0;
            strobe_q <= 1'b0;
            state_q  <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (scan_more) begin
            chan_q  <= chan_q + 4'd1;
            state_q <= ST_SETUP;
          end else begin
            scan_q  <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready   = ready_q;
  assign busy       = busy_q;
  assign dmx_a      = a_q;
  assign dmx_strobe = strobe_q;
  assign dmx_s0     = chan_q[3];
  assign dmx_s1     = chan_q[2];
  assign dmx_s2     = chan_q[1];
  assign dmx_s3     = chan_q[0];

`ifdef DMX_CHECK_EN
  logic [NUM_CHAN-1:0] y_exp;
  logic                chk_err_q;

  // Only a DRIVE cycle carrying a 1 should light an output.
  assign y_exp = ((state_q == ST_DRIVE) && data_q) ? chan_onehot(chan_q) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_err_q <= 1'b0;
    end else if (dmx_y != y_exp) begin
      chk_err_q <= 1'b1;
    end
  end

  assign chk_err = chk_err_q;
`endif

endmodule

// File: tb/tb_dmx_route_sequencer.sv
module tb_dmx_route_sequencer;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT (default timing) ----------------
  logic       in_valid = 1'b0;
  logic       in_data  = 1'b0;
  logic [3:0] in_chan  = 4'd0;
  logic       in_scan  = 1'b0;
  logic       in_ready, dmx_a, dmx_s0, dmx_s1, dmx_s2, dmx_s3, dmx_strobe, busy;

  // ---------------- DUT5 (SETTLE=3, DWELL=1) ----------------
  logic       v5 = 1'b0;
  logic       d5 = 1'b0;
  logic [3:0] c5 = 4'd0;
  logic       rdy5, a5, s0_5, s1_5, s2_5, s3_5, stb5, busy5;

`ifdef DMX_CHECK_EN
  logic        y_force = 1'b0;
  logic [15:0] dmx_y, dmx_y5;
  logic        chk_err, chk_err5;
  logic [15:0] one16 = 16'h0001;
  // Ideal demux, optionally overridden with a wrong pattern.
  assign dmx_y  = y_force ? 16'h0001 :
                  (dmx_a ? (one16 << {dmx_s0, dmx_s1, dmx_s2, dmx_s3}) : 16'h0000);
  assign dmx_y5 = a5 ? (one16 << {s0_5, s1_5, s2_5, s3_5}) : 16'h0000;
`endif

  dmx_route_sequencer u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_chan(in_chan), .in_scan(in_scan),
    .dmx_a(dmx_a), .dmx_s0(dmx_s0), .dmx_s1(dmx_s1), .dmx_s2(dmx_s2), .dmx_s3(dmx_s3),
    .dmx_strobe(dmx_strobe), .busy(busy)
`ifdef DMX_CHECK_EN
    , .dmx_y(dmx_y), .chk_err(chk_err)
`endif
  );

  dmx_route_sequencer #(.SETTLE_CYCLES(3), .DWELL_CYCLES(1)) u_dut5 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v5), .in_ready(rdy5), .in_data(d5),
    .in_chan(c5), .in_scan(1'b0),
    .dmx_a(a5), .dmx_s0(s0_5), .dmx_s1(s1_5), .dmx_s2(s2_5), .dmx_s3(s3_5),
    .dmx_strobe(stb5), .busy(busy5)
`ifdef DMX_CHECK_EN
    , .dmx_y(dmx_y5), .chk_err(chk_err5)
`endif
  );

  // Observation vector: {in_ready, busy, strobe, a, s0, s1, s2, s3}
  logic [7:0] obs1, obs5;
  assign obs1 = {in_ready, busy, dmx_strobe, dmx_a, dmx_s0, dmx_s1, dmx_s2, dmx_s3};
  assign obs5 = {rdy5, busy5, stb5, a5, s0_5, s1_5, s2_5, s3_5};

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int tests_run    = 0;
  int tests_failed = 0;
  int burst_cnt;
  int a_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected vector for cycle p (1-based) of one channel, default timing.
  function automatic logic [7:0] exp_def(input int p, input logic [3:0] ch, input logic d);
    if (p == 1)      return {4'b0100, ch};
    else if (p <= 5) return {3'b011, d, ch};
    else if (p == 6) return {4'b0100, ch};
    else             return {4'b1000, ch};
  endfunction

  // Same for SETTLE=3, DWELL=1 with data=1.
  function automatic logic [7:0] exp_s3(input int p, input logic [3:0] ch);
    if (p <= 3)      return {4'b0100, ch};
    else if (p == 4) return {4'b0111, ch};
    else if (p == 5) return {4'b0100, ch};
    else             return {4'b1000, ch};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 32'(in_ready), 32'd1);
  endtask

  // Presents a request at a negedge; returns #1 after the accepting edge (edge 0).
  task automatic start_req(input logic d, input logic [3:0] ch, input logic sc, input logic hold);
    wait_ready();
    in_valid = 1'b1;
    in_data  = d;
    in_chan  = ch;
    in_scan  = sc;
    @(posedge clk);
    #1;
    in_scan = 1'b0;
    if (!hold) in_valid = 1'b0;
  endtask

  // Compares n cycles against exp_q and checks select stability while a=1.
  task automatic run_trace(input string tag, input int n, input logic use5);
    logic [7:0] o, prev;
    logic       prev_stb;
    prev     = use5 ? obs5 : obs1;
    prev_stb = prev[5];
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      o = use5 ? obs5 : obs1;
      check($sformatf("%s_c%0d", tag, k), 32'(o), 32'(exp_q.pop_front()));
      if (o[4]) begin
        a_cnt++;
        check($sformatf("%s_selstable_c%0d", tag, k), 32'(o[3:0]), 32'(prev[3:0]));
      end
      if (o[5] && !prev_stb) burst_cnt++;
      prev     = o;
      prev_stb = o[5];
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    // Reset
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'(obs1), 32'h0);
    check("reset_outputs5", 32'(obs5), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_first_edge", 32'(obs1), 32'h80);

    // Test 1: data=1 chan 5
    start_req(1'b1, 4'd5, 1'b0, 1'b0);
    for (int k = 1; k <= 7; k++) exp_q.push_back(exp_def(k, 4'd5, 1'b1));
    run_trace("t1", 7, 1'b0);

    // Data=0 single request: strobe still marks DRIVE, a stays 0
    start_req(1'b0, 4'd12, 1'b0, 1'b0);
    for (int k = 1; k <= 7; k++) exp_q.push_back(exp_def(k, 4'd12, 1'b0));
    run_trace("t1d0", 7, 1'b0);

    // Test 2: valid held during busy with chan 9
    start_req(1'b1, 4'd5, 1'b0, 1'b1);
    in_chan = 4'd9;
    for (int k = 1; k <= 7; k++) exp_q.push_back(exp_def(k, 4'd5, 1'b1));
    for (int k = 1; k <= 7; k++) exp_q.push_back(exp_def(k, 4'd9, 1'b1));
    run_trace("t2", 8, 1'b0);
    in_valid = 1'b0;
    run_trace("t2b", 6, 1'b0);

    // Test 3: scan with data=1, in_chan ignored
    burst_cnt = 0;
    start_req(1'b1, 4'd7, 1'b1, 1'b0);
    for (int k = 1; k <= 96; k++)
      exp_q.push_back(exp_def(((k - 1) % 6) + 1, 4'((k - 1) / 6), 1'b1));
    exp_q.push_back({4'b1000, 4'd15});
    run_trace("t3", 97, 1'b0);
    check("t3_bursts", 32'(burst_cnt), 32'd16);

    // Scan with data=0: all 16 channels still strobed, a never high
    burst_cnt = 0;
    a_cnt     = 0;
    start_req(1'b0, 4'd3, 1'b1, 1'b0);
    for (int k = 1; k <= 96; k++)
      exp_q.push_back(exp_def(((k - 1) % 6) + 1, 4'((k - 1) / 6), 1'b0));
    exp_q.push_back({4'b1000, 4'd15});
    run_trace("t3d0", 97, 1'b0);
    check("t3d0_bursts", 32'(burst_cnt), 32'd16);
    check("t3d0_a_cycles", 32'(a_cnt), 32'd0);

    // Test 5: SETTLE=3, DWELL=1, back-to-back chan 15 then chan 0
    a_cnt = 0;
    @(negedge clk);
    check("t5_ready", 32'(rdy5), 32'd1);
    v5 = 1'b1;
    d5 = 1'b1;
    c5 = 4'd15;
    @(posedge clk);
    #1 c5 = 4'd0;
    for (int k = 1; k <= 6; k++) exp_q.push_back(exp_s3(k, 4'd15));
    for (int k = 1; k <= 6; k++) exp_q.push_back(exp_s3(k, 4'd0));
    run_trace("t5", 7, 1'b1);
    v5 = 1'b0;
    run_trace("t5b", 5, 1'b1);
    check("t5_a_cycles", 32'(a_cnt), 32'd2);

`ifdef DMX_CHECK_EN
    // Test 6: wrong demux output during DRIVE of chan 2
    check("t6_no_err_before", 32'({chk_err, chk_err5}), 32'd0);
    start_req(1'b1, 4'd2, 1'b0, 1'b0);
    @(negedge clk);                     // cycle 1 (SETUP)
    check("t6_err_setup", 32'(chk_err), 32'd0);
    @(negedge clk);                     // cycle 2 (DRIVE)
    y_force = 1'b1;
    @(negedge clk);                     // cycle 3
    y_force = 1'b0;
    check("t6_err_set", 32'(chk_err), 32'd1);
    repeat (6) @(negedge clk);
    check("t6_err_sticky", 32'(chk_err), 32'd1);
`endif

    // Test 4: reset during DRIVE of chan 3
    start_req(1'b1, 4'd3, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);                     // cycle 3, DRIVE
    check("t4_in_drive", 32'(obs1), 32'(exp_def(3, 4'd3, 1'b1)));
    rst_n = 1'b0;
    #1;
    check("t4_async_drop", 32'(obs1), 32'h0);
`ifdef DMX_CHECK_EN
    check("t6_err_cleared", 32'(chk_err), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t4_ready_first_edge", 32'(obs1), 32'h80);
    for (int k = 1; k <= 3; k++) exp_q.push_back(8'h80);
    run_trace("t4_idle", 3, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
